// File: rtl/brightness_seq.sv
// brightness_seq -- key-driven brightness step sequencer.
//
// Debounces a raw increase/decrease key pair, then issues one brightness
// step per accepted press, aligned to a frame boundary. While the key stays
// held, an optional auto-repeat re-arms the step every REPEAT_FRAMES frames.
//
// Configuration macro: BRIGHTNESS_SEQ_AUTO_REPEAT_EN
//   defined   -> HOLD counts frames and re-arms a step every REPEAT_FRAMES
//   undefined -> one step per press; no frame counter is built
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   enable    in   master enable; low forces idle and gates outputs
//   frame_en  in   one-cycle frame-boundary strobe
//   key_inc   in   raw increase request level
//   key_dec   in   raw decrease request level
//   binc      out  one-cycle step-up pulse
//   bdec      out  one-cycle step-down pulse
//   level     out  current brightness level, 0..MAX_LEVEL
//   pending   out  an accepted step is waiting for a frame boundary
module brightness_seq #(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_FRAMES = 8,
    parameter int MAX_LEVEL     = 15,
    parameter int RESET_LEVEL   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_en,
    input  logic       key_inc,
    input  logic       key_dec,
    output logic       binc,
    output logic       bdec,
    output logic [3:0] level,
    output logic       pending
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, ARMED, HOLD} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

    localparam int DBW = $clog2(DB_CYCLES + 1);

    state_t         state, state_n;
    dir_t           dir, dir_lat, dir_lat_n;
    logic [DBW-1:0] db_cnt, db_cnt_n;
    logic           pend_q, pend_n;
    logic           inc_q, inc_n;
    logic           dec_q, dec_n;
    logic [3:0]     level_q, level_n;

`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
    localparam int FRW = $clog2(REPEAT_FRAMES + 1);
    logic [FRW-1:0] fr_cnt, fr_cnt_n;
`endif

    // Both keys pressed together is treated as no request.
    always_comb begin
        dir = D_NONE;
        if (key_inc && !key_dec)
            dir = D_UP;
        else if (key_dec && !key_inc)
            dir = D_DN;
    end

    always_comb begin
        state_n   = state;
        dir_lat_n = dir_lat;
        db_cnt_n  = db_cnt;
        pend_n    = pend_q;
        inc_n     = 1'b0;
        dec_n     = 1'b0;
        level_n   = level_q;
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
        fr_cnt_n  = fr_cnt;
`endif
        if (!enable) begin
            state_n  = IDLE;
            pend_n   = 1'b0;
            db_cnt_n = '0;
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
            fr_cnt_n = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dir != D_NONE) begin
                        state_n   = DEBOUNCE;
                        db_cnt_n  = DBW'(1);
                        dir_lat_n = dir;
                    end
                end
                DEBOUNCE: begin
                    if (dir != dir_lat) begin
                        state_n  = IDLE;
                        db_cnt_n = '0;
                    end else if (int'(db_cnt) + 1 >= DB_CYCLES) begin
                        // Counter reaches DB_CYCLES on this edge. A frame_en
                        // in this same cycle is deliberately not consumed.
                        state_n  = ARMED;
                        pend_n   = 1'b1;
                        db_cnt_n = '0;
                    end else begin
                        db_cnt_n = db_cnt + DBW'(1);
                    end
                end
                ARMED: begin
                    if (dir != dir_lat) begin
                        state_n = IDLE;
                        pend_n  = 1'b0;
                    end else if (frame_en) begin
                        state_n = HOLD;
                        pend_n  = 1'b0;
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
                        // The consuming frame opens the repeat window.
                        fr_cnt_n = FRW'(1);
`endif
                        // Saturated steps still move to HOLD, just silently.
                        if (dir_lat == D_UP && level_q != 4'(MAX_LEVEL)) begin
                            inc_n   = 1'b1;
                            level_n = level_q + 4'd1;
                        end else if (dir_lat == D_DN && level_q != 4'd0) begin
                            dec_n   = 1'b1;
                            level_n = level_q - 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (dir != dir_lat) begin
                        state_n = IDLE;
                        pend_n  = 1'b0;
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
                        fr_cnt_n = '0;
                    end else if (frame_en) begin
                        if (int'(fr_cnt) + 1 >= REPEAT_FRAMES) begin
                            fr_cnt_n = '0;
                            pend_n   = 1'b1;
                            state_n  = ARMED;
                        end else begin
                            fr_cnt_n = fr_cnt + FRW'(1);
                        end
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            dir_lat <= D_NONE;
            db_cnt  <= '0;
            pend_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            level_q <= 4'(RESET_LEVEL);
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
            fr_cnt  <= '0;
`endif
        end else begin
            state   <= state_n;
            dir_lat <= dir_lat_n;
            db_cnt  <= db_cnt_n;
            pend_q  <= pend_n;
            inc_q   <= inc_n;
            dec_q   <= dec_n;
            level_q <= level_n;
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
            fr_cnt  <= fr_cnt_n;
`endif
        end
    end

    // Dropping enable silences outputs immediately, not one edge later.
    assign binc    = inc_q & enable;
    assign bdec    = dec_q & enable;
    assign pending = pend_q & enable;
    assign level   = level_q;

endmodule

// File: tb/tb_brightness_seq.sv
// Directed bench for brightness_seq: inputs driven and outputs sampled on
// the falling clock edge, so each @(negedge clk) spans one rising edge.
module tb_brightness_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       frame_en = 1'b0;
    logic       key_inc = 1'b0;
    logic       key_dec = 1'b0;
    logic       binc, bdec, pending;
    logic [3:0] level;

    int n_cmp = 0;
    int n_err = 0;
    int exp_lvl;
    logic exp_b;
    logic any_pulse;

    brightness_seq dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_en(frame_en),
        .key_inc(key_inc), .key_dec(key_dec),
        .binc(binc), .bdec(bdec), .level(level), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One full press: debounce, one frame, release.
    task automatic do_step(input bit up);
        key_inc = up;
        key_dec = !up;
        repeat (5) @(negedge clk);
        frame_en = 1'b1;
        @(negedge clk);
        frame_en = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_level", level, 8);
        chk("rst_pending", pending, 0);
        chk("rst_binc", binc, 0);
        chk("rst_bdec", bdec, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Held key: pending after 4 cycles, single binc after frame_en
        key_inc = 1'b1;
        repeat (3) @(negedge clk);
        chk("db_pending_early", pending, 0);
        @(negedge clk);
        chk("db_pending_rise", pending, 1);
        chk("db_no_binc", binc, 0);
        repeat (6) @(negedge clk);
        chk("armed_wait_pending", pending, 1);
        chk("armed_wait_level", level, 8);
        frame_en = 1'b1;
        @(negedge clk);
        frame_en = 1'b0;
        chk("step_binc", binc, 1);
        chk("step_level", level, 9);
        chk("step_pending_clr", pending, 0);
        @(negedge clk);
        chk("step_binc_one", binc, 0);
        key_inc = 1'b0;
        repeat (2) @(negedge clk);

        // 3-cycle glitch is rejected
        key_inc = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("glitch_pending", pending, 0);
        end
        key_inc = 1'b0;
        @(negedge clk);
        chk("glitch_pending_after", pending, 0);
        frame_en = 1'b1;
        @(negedge clk);
        frame_en = 1'b0;
        chk("glitch_binc", binc, 0);
        chk("glitch_level", level, 9);
        @(negedge clk);

        // Climb to 15, then saturated presses
        repeat (6) do_step(1'b1);
        chk("climb_level", level, 15);
        key_inc = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            frame_en = 1'b1;
            @(negedge clk);
            frame_en = 1'b0;
            chk("sat_binc", binc, 0);
            repeat (3) @(negedge clk);
        end
        chk("sat_level", level, 15);
        key_inc = 1'b0;
        repeat (2) @(negedge clk);

        // Descend to 8, then hold key_dec across 17 frames
        repeat (7) do_step(1'b0);
        chk("desc_level", level, 8);
        key_dec = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 17; k++) begin
            frame_en = 1'b1;
            @(negedge clk);
            frame_en = 1'b0;
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
            exp_b = (k == 1 || k == 9 || k == 17);
`else
            exp_b = (k == 1);
`endif
            chk($sformatf("repeat_bdec_f%0d", k), bdec, exp_b);
            repeat (3) @(negedge clk);
        end
`ifdef BRIGHTNESS_SEQ_AUTO_REPEAT_EN
        exp_lvl = 5;
`else
        exp_lvl = 7;
`endif
        chk("repeat_level", level, exp_lvl);
        key_dec = 1'b0;
        repeat (2) @(negedge clk);

        // Both keys high: no activity
        key_inc = 1'b1;
        key_dec = 1'b1;
        any_pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            frame_en = (i % 4 == 0);
            @(negedge clk);
            any_pulse = any_pulse | binc | bdec | pending;
        end
        frame_en = 1'b0;
        chk("both_keys_quiet", any_pulse, 0);
        chk("both_keys_level", level, exp_lvl);
        key_inc = 1'b0;
        key_dec = 1'b0;
        repeat (2) @(negedge clk);

        // Enable dropped while ARMED
        key_inc = 1'b1;
        repeat (5) @(negedge clk);
        chk("en_armed_pending", pending, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("en_off_pending", pending, 0);
        frame_en = 1'b1;
        @(negedge clk);
        frame_en = 1'b0;
        chk("en_off_binc", binc, 0);
        @(negedge clk);
        chk("en_off_binc2", binc, 0);
        chk("en_off_level", level, exp_lvl);
        key_inc = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Reset hits the pulse cycle
        key_inc = 1'b1;
        repeat (5) @(negedge clk);
        frame_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_binc", binc, 0);
        chk("rst_mid_level", level, 8);
        @(negedge clk);
        frame_en = 1'b0;
        key_inc = 1'b0;
        rst = 1'b1;
        any_pulse = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_pulse = any_pulse | binc | bdec;
        end
        chk("rst_after_pulse", any_pulse, 0);
        chk("rst_after_level", level, 8);
        chk("rst_after_pending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brightness_seq.md
BRIGHTNESS_SEQ -- requirements
Module: brightness_seq

Interface
REQ-001 Parameter DB_CYCLES, default 4; number of consecutive clk cycles a key direction must be stable before it is accepted.
REQ-002 Parameter REPEAT_FRAMES, default 8; number of frame_en pulses between auto-repeat steps while a key is held.
REQ-003 Parameter MAX_LEVEL, default 15; highest brightness level.
REQ-004 Parameter RESET_LEVEL, default 8; level loaded at reset, range 0..MAX_LEVEL.
REQ-005 clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  master enable; low forces idle.
REQ-008 frame_en  input  1  frame-boundary strobe, one clk cycle wide.
REQ-009 key_inc  input  1  raw increase-request level, synchronous to clk.
REQ-010 key_dec  input  1  raw decrease-request level, synchronous to clk.
REQ-011 binc  output  1  one-cycle pulse to the brightness datapath: step brightness up.
REQ-012 bdec  output  1  one-cycle pulse to the brightness datapath: step brightness down.
REQ-013 level  output  4  current brightness level, 0..MAX_LEVEL.
REQ-014 pending  output  1  high while an accepted step is waiting for a frame boundary.

Function
REQ-015 Direction is decoded as UP = key_inc&~key_dec, DN = key_dec&~key_inc, NONE otherwise; both keys high counts as NONE.
REQ-016 The FSM states are IDLE, DEBOUNCE, ARMED and HOLD.
- IDLE -> DEBOUNCE: direction != NONE; the stability counter loads 1 and the direction is latched.
REQ-017 DEBOUNCE: the counter increments while the direction equals the latched value and returns to IDLE if the direction changes.
- Counter reaches DB_CYCLES: go to ARMED, set pending.
REQ-018 ARMED: on a cycle with frame_en=1, go to HOLD and clear pending.
- Next cycle: the matching binc or bdec pulses high for exactly 1 cycle.
- Same edge as the pulse: level updates by ±1.
REQ-019 Saturation: an UP step at level==MAX_LEVEL, or a DN step at level==0, produces no pulse and leaves level unchanged; the FSM still goes to HOLD.
REQ-020 HOLD: a frame counter counts frame_en pulses.
- When the count reaches REPEAT_FRAMES: counter resets, pending sets, FSM returns to ARMED.
- Direction != latched value at any time: go to IDLE, clear pending and the counter.
REQ-021 A direction change while in ARMED returns the FSM to IDLE and clears pending.
REQ-022 binc and bdec are never high in the same cycle.
REQ-023 There is at most one step per frame_en pulse.
REQ-024 enable=0: FSM forced to IDLE; pending, binc and bdec forced to 0; level holds.
- The forced state applies from the next clk edge, and the outputs are gated to 0 combinationally.
REQ-025 A frame_en pulse in the same cycle that the debounce completes is not consumed; the step waits for the next frame_en.

Reset
REQ-026 rst low asynchronously sets state=IDLE, level=RESET_LEVEL, binc=0, bdec=0, pending=0, and clears all counters.
REQ-027 Reset asserted mid-step (ARMED, or the pulse cycle) discards the step; no pulse occurs after rst rises.
REQ-028 Release of rst takes effect on the first rising clk edge after rst goes high.

Configuration
REQ-029 Macro BRIGHTNESS_SEQ_AUTO_REPEAT_EN: defined -> HOLD behaves per REQ-020.
- Undefined: HOLD never re-arms, so each key press yields exactly one step until release, and the frame counter is not instantiated.

Verification
REQ-030 Reset at level 8, key_inc held 10 cycles, then frame_en pulse -> pending rises at cycle 4 of hold, one binc pulse in the cycle after frame_en, level=9.
REQ-031 key_inc glitch 3 cycles high then low -> no pending, no binc, level unchanged.
REQ-032 Level 15, key_inc held, 3 frame_en pulses -> binc stays 0, level stays 15.
REQ-033 AUTO_REPEAT_EN defined, key_dec held across 17 frame_en pulses from level 8 -> bdec pulses after frames 1, 9 and 17; level=5. Macro undefined -> a single pulse, level=7.
REQ-034 key_inc and key_dec both high for 20 cycles with frame_en pulsing -> no pulses; enable dropped while ARMED -> pending=0 next cycle and no pulse on the following frame_en.
REQ-035 rst asserted in the cycle a binc pulse is due -> binc stays 0, level=8 after rst releases.
